// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges NUM_REQ line-granular memory masters onto one
// memory channel with a single outstanding transaction. Arbitration is
// round-robin (RR_EN=1) or fixed priority with the lowest index winning (RR_EN=0).
// When the optional macro MEM_ARB_TIMEOUT_EN is defined, a busy-cycle watchdog is
// added. It forces completion after TIMEOUT cycles and raises the sticky
// timeout_err output.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transaction; arbitrate among pending requestors each cycle
// BUSY    | latched request driven downstream, waiting for mem_ready
// RELEASE | one dead cycle so the owner can drop its request; advance rr_ptr
module mem_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 64,
    parameter int RR_EN      = 1,
    parameter int TIMEOUT    = 1024,
    localparam int DW        = LINE_BYTES * 8,
    localparam int LAW       = ADDR_W - $clog2(LINE_BYTES),
    localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ*LAW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_load,
    input  logic [NUM_REQ-1:0]     req_store,
    output logic [DW-1:0]          resp_data,
    output logic [NUM_REQ-1:0]     resp_ready,
    output logic [LAW-1:0]         mem_addr,
    output logic [DW-1:0]          mem_data_out,
    output logic                   mem_req_load,
    output logic                   mem_req_store,
    input  logic [DW-1:0]          mem_data,
    input  logic                   mem_ready,
    output logic                   busy,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic [GID_W-1:0]       grant_id
);

    generate
        if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
            $error("mem_bus_arbiter: NUM_REQ must be 1..8");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("mem_bus_arbiter: TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state;
    logic [GID_W-1:0]     rr_ptr;
    logic [GID_W-1:0]     win_id;
    logic [NUM_REQ-1:0]   pending;
    logic                 tmo_hit;
    logic                 fire;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     tmo_cnt;

    // Watchdog expires in the TIMEOUT-th BUSY cycle when memory stays silent.
    always_comb begin
        tmo_hit = (state == BUSY) && !mem_ready && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    end
`else
    // Without the watchdog BUSY waits for mem_ready indefinitely.
    always_comb begin
        tmo_hit = 1'b0;
    end
`endif

    assign pending   = req_load | req_store;
    assign fire      = (state == BUSY) && (mem_ready || tmo_hit);
    assign resp_data = mem_data;

    // Winner search: scan upward from rr_ptr with wrap, or from index 0 for fixed priority.
    always_comb begin
        int               idx;
        logic             found;
        logic [GID_W-1:0] cand;
        idx    = 0;
        found  = 1'b0;
        cand   = '0;
        win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (RR_EN != 0) ? int'(rr_ptr) + k : k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = GID_W'(idx);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    // Completion pulse goes only to the owner, in the same cycle as mem_ready or the timeout.
    always_comb begin
        resp_ready = '0;
        if (fire) begin
            resp_ready = NUM_REQ'(1) << grant_id;
        end
    end

    // Arbitration FSM; the downstream request, address and data registers serve as the latched transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
            mem_req_load  <= 1'b0;
            mem_req_store <= 1'b0;
            busy          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant_id      <= win_id;
                        mem_addr      <= req_addr[int'(win_id)*LAW +: LAW];
                        mem_data_out  <= req_data[int'(win_id)*DW +: DW];
                        // A store wins over a simultaneous load; the load is dropped.
                        mem_req_store <= req_store[win_id];
                        mem_req_load  <= req_load[win_id] & ~req_store[win_id];
                        busy          <= 1'b1;
                        state         <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (fire) begin
                        mem_req_load  <= 1'b0;
                        mem_req_store <= 1'b0;
                        state         <= RELEASE;
`ifdef MEM_ARB_TIMEOUT_EN
                        if (tmo_hit) begin
                            timeout_err <= 1'b1;
                        end
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    rr_ptr <= (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share all inputs, so both step through the FSM in lockstep and
// differ only in which requestor they grant.
module tb_mem_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int LB      = 64;
    localparam int AW      = 64;
    localparam int DW      = LB * 8;
    localparam int LAW     = AW - $clog2(LB);

    logic                   clk;
    logic                   reset_n;
    logic [NUM_REQ*LAW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_load;
    logic [NUM_REQ-1:0]     req_store;
    logic [DW-1:0]          mem_data;
    logic                   mem_ready;

    logic [DW-1:0]      rr_resp_data, fp_resp_data;
    logic [NUM_REQ-1:0] rr_resp_ready, fp_resp_ready;
    logic [LAW-1:0]     rr_mem_addr, fp_mem_addr;
    logic [DW-1:0]      rr_mem_data_out, fp_mem_data_out;
    logic               rr_mem_req_load, fp_mem_req_load;
    logic               rr_mem_req_store, fp_mem_req_store;
    logic               rr_busy, fp_busy;
    logic [0:0]         rr_grant_id, fp_grant_id;
`ifdef MEM_ARB_TIMEOUT_EN
    logic               rr_timeout_err, fp_timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .LINE_BYTES(LB), .ADDR_W(AW), .RR_EN(1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req_addr(req_addr), .req_data(req_data),
        .req_load(req_load), .req_store(req_store), .resp_data(rr_resp_data),
        .resp_ready(rr_resp_ready), .mem_addr(rr_mem_addr), .mem_data_out(rr_mem_data_out),
        .mem_req_load(rr_mem_req_load), .mem_req_store(rr_mem_req_store),
        .mem_data(mem_data), .mem_ready(mem_ready), .busy(rr_busy),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout_err(rr_timeout_err),
`endif
        .grant_id(rr_grant_id)
    );

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .LINE_BYTES(LB), .ADDR_W(AW), .RR_EN(0), .TIMEOUT(8)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req_addr(req_addr), .req_data(req_data),
        .req_load(req_load), .req_store(req_store), .resp_data(fp_resp_data),
        .resp_ready(fp_resp_ready), .mem_addr(fp_mem_addr), .mem_data_out(fp_mem_data_out),
        .mem_req_load(fp_mem_req_load), .mem_req_store(fp_mem_req_store),
        .mem_data(mem_data), .mem_ready(mem_ready), .busy(fp_busy),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout_err(fp_timeout_err),
`endif
        .grant_id(fp_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_load  = '0;
        req_store = '0;
        mem_data  = '0;
        mem_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] pat;
        pat = {64{8'h3C}};
        do_reset();
        reset_n  = 1'b0;
        mem_data = pat;
        #1;
        checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", rr_busy); end
        checks++; if (rr_mem_req_load !== 1'b0 || rr_mem_req_store !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0b%0b expected 00", rr_mem_req_load, rr_mem_req_store); end
        checks++; if (rr_grant_id !== 1'b0 || rr_mem_addr !== '0) begin errors++; $display("FAIL rst_grant_addr: got %0d/%0h expected 0/0", rr_grant_id, rr_mem_addr); end
        checks++; if (rr_resp_ready !== 2'b00) begin errors++; $display("FAIL rst_resp_ready: got %b expected 00", rr_resp_ready); end
        checks++; if (rr_resp_data !== pat) begin errors++; $display("FAIL rst_resp_data: got %0h expected %0h", rr_resp_data, pat); end
        do_reset();
    endtask

    task automatic test_single_load();
        logic [DW-1:0] pat;
        pat = {64{8'hA5}};
        do_reset();
        req_addr[0 +: LAW] = LAW'(64'h40);
        req_load[0] = 1'b1;
        #1;
        checks++; if (rr_mem_req_load !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL load_c0: got req=%0b busy=%0b expected 0 0", rr_mem_req_load, rr_busy); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++; if (rr_mem_req_load !== 1'b1 || rr_mem_addr !== LAW'(64'h40) || rr_resp_ready !== 2'b00) begin
                errors++; $display("FAIL load_busy_c%0d: got req=%0b addr=%0h rdy=%b expected 1 40 00", c, rr_mem_req_load, rr_mem_addr, rr_resp_ready); end
        end
        step();
        mem_data  = pat;
        mem_ready = 1'b1;
        #1;
        checks++; if (rr_mem_req_load !== 1'b1 || rr_resp_ready !== 2'b01) begin errors++; $display("FAIL load_done: got req=%0b rdy=%b expected 1 01", rr_mem_req_load, rr_resp_ready); end
        checks++; if (rr_resp_data !== pat) begin errors++; $display("FAIL load_data: got %0h expected %0h", rr_resp_data, pat); end
        step();
        mem_ready = 1'b0;
        req_load  = '0;
        #1;
        checks++; if (rr_busy !== 1'b1 || rr_mem_req_load !== 1'b0 || rr_resp_ready !== 2'b00) begin errors++; $display("FAIL load_release: got busy=%0b req=%0b rdy=%b expected 1 0 00", rr_busy, rr_mem_req_load, rr_resp_ready); end
        step();
        checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL load_idle: got busy=%0b expected 0", rr_busy); end
    endtask

    task automatic test_contention();
        logic exp_g;
        do_reset();
        req_addr[0 +: LAW]   = LAW'(64'h100);
        req_addr[LAW +: LAW] = LAW'(64'h200);
        req_load = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 1);
            step();
            checks++; if (rr_grant_id !== exp_g) begin errors++; $display("FAIL rr_grant_t%0d: got %0d expected %0d", t, rr_grant_id, exp_g); end
            checks++; if (rr_mem_addr !== (exp_g ? LAW'(64'h200) : LAW'(64'h100))) begin errors++; $display("FAIL rr_addr_t%0d: got %0h", t, rr_mem_addr); end
            checks++; if (fp_grant_id !== 1'b0) begin errors++; $display("FAIL fp_grant_t%0d: got %0d expected 0", t, fp_grant_id); end
            mem_ready = 1'b1;
            #1;
            checks++; if (rr_resp_ready !== (exp_g ? 2'b10 : 2'b01) || fp_resp_ready !== 2'b01) begin
                errors++; $display("FAIL arb_rdy_t%0d: got rr=%b fp=%b expected rr=%b fp=01", t, rr_resp_ready, fp_resp_ready, exp_g ? 2'b10 : 2'b01); end
            step();
            mem_ready = 1'b0;
            #1;
            checks++; if (rr_mem_req_load !== 1'b0 || fp_mem_req_load !== 1'b0 || rr_busy !== 1'b1) begin
                errors++; $display("FAIL arb_release_t%0d: got rr=%0b fp=%0b busy=%0b expected 0 0 1", t, rr_mem_req_load, fp_mem_req_load, rr_busy); end
            step();
            checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL arb_idle_t%0d: got busy=%0b expected 0", t, rr_busy); end
        end
        req_load = '0;
        step();
        step();
    endtask

    task automatic test_store_latch();
        do_reset();
        req_addr[LAW +: LAW] = LAW'(64'h77);
        req_data[DW +: DW]   = DW'(16'h1234);
        req_store[1] = 1'b1;
        req_load[1]  = 1'b1;
        step();
        checks++; if (rr_grant_id !== 1'b1 || fp_grant_id !== 1'b1) begin errors++; $display("FAIL st_grant: got rr=%0d fp=%0d expected 1 1", rr_grant_id, fp_grant_id); end
        checks++; if (rr_mem_req_store !== 1'b1 || rr_mem_req_load !== 1'b0) begin errors++; $display("FAIL st_type: got st=%0b ld=%0b expected 1 0", rr_mem_req_store, rr_mem_req_load); end
        req_addr[LAW +: LAW] = LAW'(64'h99);
        req_data[DW +: DW]   = DW'(16'hFFFF);
        step();
        checks++; if (rr_mem_addr !== LAW'(64'h77) || rr_mem_data_out !== DW'(16'h1234)) begin errors++; $display("FAIL st_latched: got addr=%0h data=%0h expected 77 1234", rr_mem_addr, rr_mem_data_out); end
        mem_ready = 1'b1;
        #1;
        checks++; if (rr_resp_ready !== 2'b10 || rr_mem_data_out !== DW'(16'h1234)) begin errors++; $display("FAIL st_done: got rdy=%b data=%0h expected 10 1234", rr_resp_ready, rr_mem_data_out); end
        step();
        mem_ready = 1'b0;
        req_load  = '0;
        req_store = '0;
        step();
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] pat;
        pat = {64{8'h5A}};
        do_reset();
        req_addr[0 +: LAW] = LAW'(64'h10);
        req_load[0] = 1'b1;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        req_load  = 2'b11;
        step();
        step();
        checks++; if (rr_grant_id !== 1'b1 || rr_busy !== 1'b1) begin errors++; $display("FAIL ar_pre_grant: got g=%0d busy=%0b expected 1 1", rr_grant_id, rr_busy); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (rr_busy !== 1'b0 || rr_mem_req_load !== 1'b0 || rr_grant_id !== 1'b0 || rr_mem_addr !== '0) begin
            errors++; $display("FAIL ar_async: got busy=%0b req=%0b g=%0d addr=%0h expected all 0", rr_busy, rr_mem_req_load, rr_grant_id, rr_mem_addr); end
        mem_ready = 1'b1;
        mem_data  = pat;
        #1;
        checks++; if (rr_resp_ready !== 2'b00 || rr_resp_data !== pat) begin errors++; $display("FAIL ar_resp: got rdy=%b data=%0h expected 00 %0h", rr_resp_ready, rr_resp_data, pat); end
        mem_ready = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (rr_grant_id !== 1'b0 || rr_mem_req_load !== 1'b1) begin errors++; $display("FAIL ar_regrant: got g=%0d req=%0b expected 0 1", rr_grant_id, rr_mem_req_load); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        req_load  = '0;
        step();
    endtask

    task automatic test_spurious_ready();
        do_reset();
        mem_ready = 1'b1;
        #1;
        checks++; if (rr_resp_ready !== 2'b00 || fp_resp_ready !== 2'b00) begin errors++; $display("FAIL sp_idle_rdy: got rr=%b fp=%b expected 00 00", rr_resp_ready, fp_resp_ready); end
        step();
        checks++; if (rr_busy !== 1'b0 || rr_resp_ready !== 2'b00) begin errors++; $display("FAIL sp_idle_state: got busy=%0b rdy=%b expected 0 00", rr_busy, rr_resp_ready); end
        mem_ready   = 1'b0;
        req_load[0] = 1'b1;
        step();
        mem_ready = 1'b1;
        #1;
        checks++; if (rr_resp_ready !== 2'b01) begin errors++; $display("FAIL sp_busy_rdy: got %b expected 01", rr_resp_ready); end
        step();
        req_load = '0;
        #1;
        checks++; if (rr_resp_ready !== 2'b00 || rr_busy !== 1'b1) begin errors++; $display("FAIL sp_release_rdy: got rdy=%b busy=%0b expected 00 1", rr_resp_ready, rr_busy); end
        mem_ready = 1'b0;
        step();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_load[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++; if (rr_resp_ready !== 2'b00 || rr_timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait_c%0d: got rdy=%b err=%0b expected 00 0", c, rr_resp_ready, rr_timeout_err); end
        end
        step();
        checks++; if (rr_resp_ready !== 2'b01) begin errors++; $display("FAIL to_pulse: got %b expected 01", rr_resp_ready); end
        step();
        req_load = '0;
        #1;
        checks++; if (rr_timeout_err !== 1'b1 || rr_mem_req_load !== 1'b0) begin errors++; $display("FAIL to_err: got err=%0b req=%0b expected 1 0", rr_timeout_err, rr_mem_req_load); end
        step();
        step();
        step();
        checks++; if (rr_timeout_err !== 1'b1 || rr_busy !== 1'b0) begin errors++; $display("FAIL to_sticky: got err=%0b busy=%0b expected 1 0", rr_timeout_err, rr_busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (rr_timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b expected 0", rr_timeout_err); end
        do_reset();
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_load  = '0;
        req_store = '0;
        mem_data  = '0;
        mem_ready = 1'b0;
        test_reset();
        test_single_load();
        test_contention();
        test_store_latch();
        test_async_reset();
        test_spurious_ready();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- N-requestor arbiter merging several line-granular memory masters (I-cache, D-cache, future TLB walker/DMA) onto the single mem_bus_req/mem_bus_resp channel.
- Generalises the fixed 2-way cache-to-memory hookup in three ways: parametrised requestor count, parametrised line size, and selectable round-robin or fixed-priority mode.
- Sits between the cache layer and the memory model/controller.
- Holds exactly one outstanding transaction and routes the response back to its owner only.

Parameters:
- NUM_REQ, 2, number of requestors (1..8).
- LINE_BYTES, 64, bytes per line (power of 2); data width DW = LINE_BYTES*8.
- ADDR_W, 64, byte-address width; line address width LAW = ADDR_W - log2(LINE_BYTES).
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 1024, busy-cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_addr  in  NUM_REQ*LAW  per-requestor line address; slot i at [i*LAW +: LAW].
- req_data  in  NUM_REQ*DW  per-requestor store line.
- req_load  in  NUM_REQ  per-requestor load request (level).
- req_store  in  NUM_REQ  per-requestor store request (level).
- resp_data  out  DW  broadcast read line (= mem_data).
- resp_ready  out  NUM_REQ  one-hot completion pulse to the owner.
- mem_addr  out  LAW  downstream line address.
- mem_data_out  out  DW  downstream store data.
- mem_req_load  out  1  downstream load request.
- mem_req_store  out  1  downstream store request.
- mem_data  in  DW  downstream read data.
- mem_ready  in  1  downstream completion (1-cycle pulse).
- busy  out  1  transaction in flight.
- grant_id  out  $clog2(NUM_REQ) (min 1)  owner of the current/last transaction.

Behaviour:
- Requestor protocol:
  - Raise load or store and hold it, with addr/data stable, until its resp_ready pulse.
  - Drop it no earlier than the cycle after the pulse.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - pending[i] = req_load[i] | req_store[i].
  - If any pending: choose the winner, latch addr, data and type into registers, set grant_id, go to BUSY.
  - Otherwise stay in IDLE.
  - mem_req_* = 0.
- Winner selection:
  - RR_EN=1: first pending index scanning upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - RR_EN=0: lowest pending index.
- BUSY:
  - mem_req_load/mem_req_store driven from the latched type; mem_addr/mem_data_out driven from the latched registers.
  - Outputs stay stable for the whole of BUSY; later requestor changes are ignored.
  - On mem_ready: resp_ready[grant_id] = 1 combinationally in that same cycle, and the state goes to RELEASE.
- RELEASE:
  - Exactly one cycle. mem_req_* = 0, no arbitration.
  - Lets the owner drop its stale request.
  - rr_ptr <= (grant_id+1) mod NUM_REQ. rr_ptr is unused when RR_EN=0.
  - Next state is IDLE.
- Latency: request seen in IDLE at edge k -> mem_req_* high from cycle k+1. Minimum turnaround between back-to-back grants is 3 cycles plus memory latency.
- Both load and store asserted by one requestor: store wins and is recorded as a store. The load is not reissued.
- mem_ready while in IDLE or RELEASE: ignored, no resp_ready.
- resp_ready is all-zero outside BUSY&mem_ready. resp_data = mem_data at all times.
- busy = (state != IDLE).
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, rr_ptr=0, grant_id=0, latched addr/data/type=0. All outputs 0 except resp_data, which follows mem_data. An in-flight transaction is dropped and its resp_ready is never issued.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky, cleared only by reset).
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without mem_ready: set timeout_err, pulse resp_ready[grant_id] (resp_data is don't-care), go to RELEASE.
- Undefined: no counter, no port; BUSY waits indefinitely.

Test Plan:
- Single load: NUM_REQ=2, req_load[0]=1, addr 0x40, mem_ready 4 cycles later with data 0xA5... -> mem_req_load high cycles 1-4, mem_addr=0x40, resp_ready=2'b01 on the mem_ready cycle, resp_data=0xA5...
- Contention, RR_EN=1: req 0 and 1 held from cycle 0 -> grants alternate 0,1,0,1 over four transactions; each grant is followed by one RELEASE cycle with mem_req_*=0.
- Fixed priority, RR_EN=0: req 0 and 1 always pending -> req 0 granted every time, req 1 never.
- Store with data 0x1234 on req 1, req_addr changed mid-BUSY -> mem_data_out=0x1234 and mem_addr stay latched until mem_ready. Asserting load and store together -> mem_req_store=1, mem_req_load=0.
- Reset_n pulsed low mid-BUSY -> outputs 0 immediately (asynchronously); after release, a pending requestor is re-granted from IDLE with rr_ptr=0. Spurious mem_ready in IDLE -> resp_ready stays 0.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=8, memory never answers -> resp_ready[grant] pulses in the 8th BUSY cycle and timeout_err=1, which stays set until reset.
